// File: rtl/ipi_histogrammer_pkg.sv
// ---------------------------------------------------------------------------
// ipi_histogrammer_pkg
// Shared defaults and types for the inter-pulse-interval histogrammer:
// channel/bin counts, interval counter width, the 32-bit count type with its
// saturation ceiling, and the arming FSM state encoding.
// ---------------------------------------------------------------------------
package ipi_histogrammer_pkg;

  localparam int NCHAN     = 8;
  localparam int NBINS     = 64;
  localparam int BIN_SHIFT = 0;
  localparam int ICNT_W    = 16;
  localparam int COUNT_W   = 32;

  typedef logic [COUNT_W-1:0] count_t;

  localparam count_t COUNT_MAX = '1;

  typedef enum logic {
    UNARMED = 1'b0,
    ARMED   = 1'b1
  } ipi_state_t;

endpackage

// File: rtl/ipi_histogrammer_if.sv
// ---------------------------------------------------------------------------
// ipi_histogrammer_if
// Bundles the histogrammer's processor-facing signals.
//   pmt       : NCHAN discriminator inputs (asynchronous to clk)
//   resethist : one-cycle clear request from the command processor
//   h         : per-channel hit counts
//   ipihist   : inter-pulse-interval bin counts
//   armed     : a first event has been seen since reset/clear
// Modports: slave = histogrammer side, master = processor/feeder side.
// ---------------------------------------------------------------------------
interface ipi_histogrammer_if
  import ipi_histogrammer_pkg::*;
#(
  parameter int NCHAN = ipi_histogrammer_pkg::NCHAN,
  parameter int NBINS = ipi_histogrammer_pkg::NBINS
);

  logic [NCHAN-1:0] pmt;
  logic             resethist;
  count_t           h       [NCHAN];
  count_t           ipihist [NBINS];
  logic             armed;

  modport slave (
    input  pmt,
    input  resethist,
    output h,
    output ipihist,
    output armed
  );

  modport master (
    output pmt,
    output resethist,
    input  h,
    input  ipihist,
    input  armed
  );

endinterface

// File: rtl/ipi_histogrammer_pulse_edge_sync.sv
// ---------------------------------------------------------------------------
// pulse_edge_sync
// Two-flop synchroniser followed by a registered rising-edge detector.
// A rising edge on async_in yields a single-cycle pulse three clocks later.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   async_in   : raw discriminator level, asynchronous to clk
//   pulse      : one-cycle registered rising-edge pulse
// ---------------------------------------------------------------------------
module pulse_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/ipi_histogrammer.sv
// ---------------------------------------------------------------------------
// ipi_histogrammer
// Counts rising edges on each PMT discriminator input and histograms the
// intervals between successive events (OR of all channels) into NBINS bins.
// A resethist pulse clears every count and disarms the interval logic.
// Ports:
//   clk   : system clock (shared with the command processor)
//   rst_n : asynchronous active-low reset
//   bus   : ipi_histogrammer_if.slave (pmt, resethist, h, ipihist, armed)
// Build option:
//   IPI_OVERFLOW_BIN_EN : when defined, intervals beyond the last bin land in
//   bin NBINS-1; otherwise they are dropped from the histogram.
// ---------------------------------------------------------------------------
module ipi_histogrammer
  import ipi_histogrammer_pkg::*;
#(
  parameter int NCHAN     = ipi_histogrammer_pkg::NCHAN,
  parameter int NBINS     = ipi_histogrammer_pkg::NBINS,
  parameter int BIN_SHIFT = ipi_histogrammer_pkg::BIN_SHIFT,
  parameter int ICNT_W    = ipi_histogrammer_pkg::ICNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  ipi_histogrammer_if.slave   bus
);

  localparam int BIN_W = (NBINS > 1) ? $clog2(NBINS) : 1;
  localparam logic [ICNT_W-1:0] ICNT_MAX = '1;

  function automatic count_t sat_inc_count(input count_t v);
    return (v == COUNT_MAX) ? v : v + count_t'(1);
  endfunction

  function automatic logic [ICNT_W-1:0] sat_inc_icnt(input logic [ICNT_W-1:0] v);
    return (v == ICNT_MAX) ? v : v + ICNT_W'(1);
  endfunction

  logic [NCHAN-1:0] edge_pulse;
  logic             clear;
  logic             evt;

  assign clear = bus.resethist;
  assign evt   = |edge_pulse;

  for (genvar i = 0; i < NCHAN; i++) begin : g_ch
    count_t h_q, h_d;

    pulse_edge_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (bus.pmt[i]),
      .pulse    (edge_pulse[i])
    );

    always_comb begin
      h_d = h_q;
      if (clear) begin
        h_d = '0;
      end else if (edge_pulse[i]) begin
        h_d = sat_inc_count(h_q);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        h_q <= '0;
      end else begin
        h_q <= h_d;
      end
    end

    assign bus.h[i] = h_q;
  end

  // Arming FSM and interval counter
  ipi_state_t        state_q, state_d;
  logic [ICNT_W-1:0] icnt_q,  icnt_d;

  always_comb begin
    state_d = state_q;
    icnt_d  = sat_inc_icnt(icnt_q);
    if (clear) begin
      state_d = UNARMED;
      icnt_d  = '0;
    end else begin
      if (evt) begin
        icnt_d = ICNT_W'(1);
      end
      unique case (state_q)
        UNARMED: if (evt) state_d = ARMED;
        ARMED:   state_d = ARMED;
        default: state_d = UNARMED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNARMED;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
    end
  end

  assign bus.armed = (state_q == ARMED);

  // Stage 1: capture the interval of an event seen while armed
  logic              vld_p1_q, vld_p1_d;
  logic [ICNT_W-1:0] interval_p1_q, interval_p1_d;

  always_comb begin
    vld_p1_d      = !clear && evt && (state_q == ARMED);
    interval_p1_d = icnt_q;
  end

  // Stage 2: map interval to a bin and decide whether it is recorded
  logic              vld_p2_q, vld_p2_d;
  logic [BIN_W-1:0]  bin_p2_q, bin_p2_d;
  logic [ICNT_W-1:0] shifted;
  logic              in_range;

  always_comb begin
    shifted  = interval_p1_q >> BIN_SHIFT;
    in_range = (shifted < ICNT_W'(NBINS));
    bin_p2_d = in_range ? shifted[BIN_W-1:0] : BIN_W'(NBINS - 1);
`ifdef IPI_OVERFLOW_BIN_EN
    vld_p2_d = !clear && vld_p1_q;
`else
    vld_p2_d = !clear && vld_p1_q && in_range;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // Pipeline data carries no reset; it is only consumed alongside its valid.
  always_ff @(posedge clk) begin
    interval_p1_q <= interval_p1_d;
    bin_p2_q      <= bin_p2_d;
  end

  // Stage 3: histogram update; a clear in the same cycle wins
  count_t ipihist_q [NBINS];
  count_t ipihist_d [NBINS];

  always_comb begin
    ipihist_d = ipihist_q;
    if (clear) begin
      for (int b = 0; b < NBINS; b++) begin
        ipihist_d[b] = '0;
      end
    end else if (vld_p2_q) begin
      ipihist_d[bin_p2_q] = sat_inc_count(ipihist_q[bin_p2_q]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBINS; b++) begin
        ipihist_q[b] <= '0;
      end
    end else begin
      ipihist_q <= ipihist_d;
    end
  end

  assign bus.ipihist = ipihist_q;

endmodule

// File: tb/tb_ipi_histogrammer.sv
// ---------------------------------------------------------------------------
// tb_ipi_histogrammer
// Directed and randomized stimulus for ipi_histogrammer. Inputs change on the
// falling clock edge; outputs are compared on falling edges against an
// event-level model (rising edges per drive cycle, interval = cycles between
// events). Honours IPI_OVERFLOW_BIN_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_ipi_histogrammer;
  import ipi_histogrammer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ipi_histogrammer_if bus ();

  ipi_histogrammer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0]      exp_h    [NCHAN];
  logic [31:0]      exp_hist [NBINS];
  bit               exp_armed;
  int               cyc;
  int               last_evt;
  logic [NCHAN-1:0] prev_pmt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCHAN; i++) exp_h[i] = '0;
    for (int b = 0; b < NBINS; b++) exp_hist[b] = '0;
    exp_armed = 1'b0;
  endtask

  task automatic model_apply(input logic [NCHAN-1:0] v);
    logic [NCHAN-1:0] rising;
    int d;
    int b;
    rising   = v & ~prev_pmt;
    prev_pmt = v;
    for (int i = 0; i < NCHAN; i++)
      if (rising[i] && exp_h[i] != 32'hFFFF_FFFF) exp_h[i] = exp_h[i] + 1;
    if (rising != '0) begin
      if (exp_armed) begin
        d = cyc - last_evt;
        if (d > (1 << ICNT_W) - 1) d = (1 << ICNT_W) - 1;
        b = d >> BIN_SHIFT;
        if (b < NBINS) exp_hist[b] = exp_hist[b] + 1;
`ifdef IPI_OVERFLOW_BIN_EN
        else exp_hist[NBINS-1] = exp_hist[NBINS-1] + 1;
`endif
      end else begin
        exp_armed = 1'b1;
      end
      last_evt = cyc;
    end
    cyc++;
  endtask

  // Drive one clock cycle of pmt (called on a falling edge)
  task automatic step(input logic [NCHAN-1:0] v);
    bus.pmt = v;
    model_apply(v);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0);
  endtask

  task automatic clear_hist();
    bus.resethist = 1'b1;
    step('0);
    bus.resethist = 1'b0;
    model_clear();
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_armed"}, {31'd0, bus.armed}, {31'd0, exp_armed});
    for (int i = 0; i < NCHAN; i++)
      chk($sformatf("%s_h%0d", tag, i), bus.h[i], exp_h[i]);
    for (int b = 0; b < NBINS; b++)
      chk($sformatf("%s_bin%0d", tag, b), bus.ipihist[b], exp_hist[b]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCHAN-1:0] v;
    bus.pmt       = '0;
    bus.resethist = 1'b0;
    prev_pmt      = '0;
    cyc           = 0;
    last_evt      = 0;
    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_armed", {31'd0, bus.armed}, 32'd0);
    chk("rst_h3", bus.h[3], 32'd0);
    chk("rst_bin20", bus.ipihist[20], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("rst");

    // Five pulses on channel 3, 20 cycles apart
    for (int p = 0; p < 5; p++) begin
      step(8'h08);
      idle(19);
    end
    idle(4);
    chk("t1_h3", bus.h[3], 32'd5);
    chk("t1_bin20", bus.ipihist[20], 32'd4);
    chk("t1_armed", {31'd0, bus.armed}, 32'd1);
    check_all("t1");

    // Simultaneous channels 0 and 5, then channel 1 ten cycles later
    clear_hist();
    check_all("t2clr");
    step(8'h21);
    idle(9);
    step(8'h02);
    idle(8);
    chk("t2_h0", bus.h[0], 32'd1);
    chk("t2_h5", bus.h[5], 32'd1);
    chk("t2_h1", bus.h[1], 32'd1);
    chk("t2_bin10", bus.ipihist[10], 32'd1);
    check_all("t2");

    // Interval of 100 cycles, beyond the last bin
    clear_hist();
    step(8'h01);
    idle(99);
    step(8'h01);
    idle(8);
    chk("t3_h0", bus.h[0], 32'd2);
`ifdef IPI_OVERFLOW_BIN_EN
    chk("t3_bin63", bus.ipihist[63], 32'd1);
`else
    chk("t3_bin63", bus.ipihist[63], 32'd0);
`endif
    check_all("t3");

    // Back-to-back events on different channels: interval 1
    clear_hist();
    step(8'h01);
    step(8'h03);
    idle(8);
    chk("t3b_bin1", bus.ipihist[1], 32'd1);
    check_all("t3b");

    // Clear coinciding with the second event's edge pulse
    clear_hist();
    step(8'h01);
    idle(9);
    step(8'h02);
    idle(2);
    clear_hist();
    chk("t4_armed", {31'd0, bus.armed}, 32'd0);
    chk("t4_h1", bus.h[1], 32'd0);
    check_all("t4clr");
    idle(6);
    step(8'h04);
    idle(8);
    chk("t4_rearm", {31'd0, bus.armed}, 32'd1);
    chk("t4_h2", bus.h[2], 32'd1);
    check_all("t4");

    // Hit counter saturation
    clear_hist();
    force dut.g_ch[2].h_q = 32'hFFFF_FFFE;
    step('0);
    release dut.g_ch[2].h_q;
    exp_h[2] = 32'hFFFF_FFFE;
    for (int p = 0; p < 3; p++) begin
      step(8'h04);
      idle(2);
    end
    idle(6);
    chk("t5_h2sat", bus.h[2], 32'hFFFF_FFFF);
    check_all("t5");

    // Randomized activity
    clear_hist();
    v = '0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0) v = NCHAN'($urandom);
      else if ($urandom_range(0, 1) == 0) v = '0;
      step(v);
    end
    idle(8);
    check_all("rnd");

    // Asynchronous reset with the pipeline busy
    step(8'h10);
    step(8'h30);
    step(8'h01);
    step(8'h00);
    #2;
    rst_n   = 1'b0;
    bus.pmt = '0;
    #1;
    chk("t6_async_h4", bus.h[4], 32'd0);
    chk("t6_async_armed", {31'd0, bus.armed}, 32'd0);
    model_clear();
    prev_pmt = '0;
    check_all("t6async");
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    check_all("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
